mpu6050_sequencer: RTL and testbench

MPU6050_SEQUENCER -- requirements
Module: mpu6050_sequencer

---
 rtl/mpu6050_sequencer_pkg.sv | 26 ++
 rtl/mpu6050_sequencer_sample_timer.sv | 29 ++
 rtl/mpu6050_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_mpu6050_sequencer.sv | 550 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpu6050_sequencer_pkg.sv
// Shared constants, encodings and state type for the MPU6050 sequencer.
// Register map values follow the MPU6050 datasheet.
package mpu6050_sequencer_pkg;

  localparam logic [7:0] REG_PWR_MGMT_1   = 8'h6B;
  localparam logic [7:0] REG_WHO_AM_I     = 8'h75;
  localparam logic [7:0] REG_ACCEL_XOUT_H = 8'h3B;
  localparam logic [7:0] WHO_AM_I_VAL     = 8'h68;
  localparam logic [7:0] WAKE_VAL         = 8'h00;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam int BURST_LEN = 6;

  typedef enum logic [2:0] {
    IDLE,
    WAKE,
    CHECK,
    WAIT_TICK,
    BURST,
    PUBLISH,
    FAULT
  } seq_state_t;

endpackage

// File: rtl/mpu6050_sequencer_sample_timer.sv
// sample_timer: free-running 0..DIV-1 counter with a wrap pulse.
// Held at zero while run is low.
module mpu6050_sequencer_sample_timer #(
  parameter int DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic wrap
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  assign wrap = run && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!run || wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mpu6050_sequencer.sv
// MPU6050 sequencer: wake, identify, then periodic accel bursts
// over a byte-oriented I2C master.
module mpu6050_sequencer
  import mpu6050_sequencer_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h68,
  parameter int         SAMPLE_DIV = 1000,
  parameter int         MAX_RETRY  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        i2c_busy,
  input  logic        i2c_done,
  input  logic        i2c_nack,
  input  logic [7:0]  i2c_rdata,
  output logic        i2c_start,
  output logic [6:0]  i2c_slave_addr,
  output logic        i2c_rw,
  output logic [7:0]  i2c_reg_addr,
  output logic [7:0]  i2c_wdata,
  output logic [15:0] accel_x,
  output logic [15:0] accel_y,
  output logic [15:0] accel_z,
  output logic        sample_valid,
  output logic        init_done,
  output logic        error
);

  localparam int RW = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;
  localparam logic [RW-1:0] LAST_TRY = RW'(MAX_RETRY - 1);
  localparam logic [2:0] LAST_BYTE = 3'(BURST_LEN - 1);

  seq_state_t state, state_d;

  logic          pending, pending_d;
  logic [2:0]    byte_idx, idx_d;
  logic [RW-1:0] retry, retry_d;
  logic [47:0]   shadow, shadow_d;
  logic          init_d, error_d;
  logic          publish;
  logic          wrap;
  logic          is_txn;
  logic          issue;
  logic          take;

  mpu6050_sequencer_sample_timer #(
    .DIV (SAMPLE_DIV)
  ) u_sample_timer (
    .clk  (clk),
    .rst  (rst),
    .run  (init_done),
    .wrap (wrap)
  );

  assign is_txn = (state == WAKE) || (state == CHECK) ||
                  (state == BURST);
  assign issue  = is_txn && !pending && !i2c_busy && en;
  // Done pulses with nothing outstanding are stray and dropped.
  assign take   = pending && i2c_done;

  assign i2c_start      = issue;
  assign i2c_slave_addr = SLAVE_ADDR;
  assign sample_valid   = (state == PUBLISH);

  // Command fields decode from state, so they hold until done.
  always_comb begin
    i2c_rw       = RW_READ;
    i2c_reg_addr = 8'h00;
    i2c_wdata    = 8'h00;
    unique case (state)
      WAKE: begin
        i2c_rw       = RW_WRITE;
        i2c_reg_addr = REG_PWR_MGMT_1;
        i2c_wdata    = WAKE_VAL;
      end
      CHECK: i2c_reg_addr = REG_WHO_AM_I;
      BURST: i2c_reg_addr = REG_ACCEL_XOUT_H + {5'b0, byte_idx};
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state;
    pending_d = pending;
    idx_d     = byte_idx;
    retry_d   = retry;
    shadow_d  = shadow;
    init_d    = init_done;
    error_d   = error;
    publish   = 1'b0;
    if (issue) pending_d = 1'b1;
    if (take)  pending_d = 1'b0;
    unique case (state)
      IDLE: begin
        idx_d   = '0;
        retry_d = '0;
        if (en) state_d = WAKE;
      end
      WAKE: begin
        if (take) begin
          if (!en) begin
            state_d = IDLE;
          end else if (i2c_nack) begin
            state_d = FAULT;
            error_d = 1'b1;
          end else begin
            state_d = CHECK;
          end
        end else if (!en && !pending) begin
          state_d = IDLE;
        end
      end
      CHECK: begin
        if (take) begin
          if (!en) begin
            state_d = IDLE;
          end else if (!i2c_nack && i2c_rdata == WHO_AM_I_VAL) begin
            state_d = WAIT_TICK;
            init_d  = 1'b1;
            retry_d = '0;
          end else if (retry == LAST_TRY) begin
            state_d = FAULT;
            error_d = 1'b1;
          end else begin
            retry_d = retry + 1'b1;
          end
        end else if (!en && !pending) begin
          state_d = IDLE;
        end
      end
      WAIT_TICK: begin
        if (!en) begin
          state_d = IDLE;
        end else if (wrap) begin
          state_d = BURST;
          idx_d   = '0;
        end
      end
      BURST: begin
        if (take) begin
          if (!en) begin
            state_d = IDLE;
          end else if (i2c_nack) begin
            state_d = FAULT;
            error_d = 1'b1;
          end else begin
            shadow_d = {shadow[39:0], i2c_rdata};
            if (byte_idx == LAST_BYTE) begin
              state_d = PUBLISH;
              idx_d   = '0;
              publish = 1'b1;
            end else begin
              idx_d = byte_idx + 1'b1;
            end
          end
        end else if (!en && !pending) begin
          state_d = IDLE;
        end
      end
      PUBLISH: state_d = en ? WAIT_TICK : IDLE;
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase
    if (state_d == IDLE) init_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending   <= 1'b0;
      byte_idx  <= '0;
      retry     <= '0;
      shadow    <= '0;
      init_done <= 1'b0;
      error     <= 1'b0;
      accel_x   <= '0;
      accel_y   <= '0;
      accel_z   <= '0;
    end else begin
      pending   <= pending_d;
      byte_idx  <= idx_d;
      retry     <= retry_d;
      shadow    <= shadow_d;
      init_done <= init_d;
      error     <= error_d;
      // Whole triple lands together as PUBLISH is entered.
      if (publish) begin
        accel_x <= shadow_d[47:32];
        accel_y <= shadow_d[31:16];
        accel_z <= shadow_d[15:0];
      end
    end
  end

endmodule

// File: tb/tb_mpu6050_sequencer.sv
// Bench for mpu6050_sequencer: I2C slave model, transaction log
// and sample reference built from the bytes actually served.
module tb_mpu6050_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        i2c_busy;
  logic        i2c_done;
  logic        i2c_nack;
  logic [7:0]  i2c_rdata;
  logic        i2c_start;
  logic [6:0]  i2c_slave_addr;
  logic        i2c_rw;
  logic [7:0]  i2c_reg_addr;
  logic [7:0]  i2c_wdata;
  logic [15:0] accel_x, accel_y, accel_z;
  logic        sample_valid;
  logic        init_done;
  logic        error;

  mpu6050_sequencer #(
    .SLAVE_ADDR (7'h68),
    .SAMPLE_DIV (20),
    .MAX_RETRY  (3)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .i2c_busy       (i2c_busy),
    .i2c_done       (i2c_done),
    .i2c_nack       (i2c_nack),
    .i2c_rdata      (i2c_rdata),
    .i2c_start      (i2c_start),
    .i2c_slave_addr (i2c_slave_addr),
    .i2c_rw         (i2c_rw),
    .i2c_reg_addr   (i2c_reg_addr),
    .i2c_wdata      (i2c_wdata),
    .accel_x        (accel_x),
    .accel_y        (accel_y),
    .accel_z        (accel_z),
    .sample_valid   (sample_valid),
    .init_done      (init_done),
    .error          (error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       rw;
    logic [7:0] addr;
    logic [7:0] wd;
    logic [7:0] rd;
    logic       nack;
    int         scyc;
    int         dcyc;
  } txn_t;

  typedef struct {
    int          cyc;
    logic [15:0] x, y, z;
    logic [15:0] ex, ey, ez;
    bit          seq_ok;
  } smp_t;

  txn_t log_q[$];
  smp_t sv_q[$];

  int total = 0;
  int bad = 0;
  int stab_err = 0;
  int ovl_err = 0;
  bit m_active = 0;
  int max_lat = 1;
  bit rand_burst = 0;
  logic [7:0] who_val = 8'h68;
  logic [7:0] nack_addr = 8'hFF;
  logic [7:0] burst_b [6];

  function automatic logic [7:0] model_read(input logic [7:0] a);
    if (a == 8'h75) return who_val;
    if (a >= 8'h3B && a <= 8'h40) begin
      if (rand_burst) return 8'($urandom);
      return burst_b[int'(a) - 'h3B];
    end
    return 8'h00;
  endfunction

  // I2C master/slave model: answers each start after 0..max_lat
  // extra busy cycles and logs the completed transaction.
  initial begin : master
    txn_t tr;
    int lat;
    i2c_busy  = 1'b0;
    i2c_done  = 1'b0;
    i2c_nack  = 1'b0;
    i2c_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (i2c_start === 1'b1) begin
        m_active = 1'b1;
        tr.rw   = i2c_rw;
        tr.addr = i2c_reg_addr;
        tr.wd   = i2c_wdata;
        tr.scyc = cyc;
        tr.dcyc = 0;
        tr.nack = (i2c_reg_addr == nack_addr);
        tr.rd   = i2c_rw ? model_read(i2c_reg_addr) : 8'h00;
        lat = $urandom_range(max_lat, 0);
        @(posedge clk);
        #1;
        i2c_busy = 1'b1;
        for (int k = 0; k <= lat; k++) begin
          if (k == lat) begin
            i2c_busy  = 1'b0;
            i2c_done  = 1'b1;
            i2c_nack  = tr.nack;
            i2c_rdata = tr.rd;
          end
          @(negedge clk);
          if (k == lat) tr.dcyc = cyc;
          if (!rst && (i2c_rw !== tr.rw ||
              i2c_reg_addr !== tr.addr ||
              i2c_wdata !== tr.wd))
            stab_err++;
          if (i2c_start === 1'b1) ovl_err++;
          @(posedge clk);
          #1;
        end
        i2c_done  = 1'b0;
        i2c_nack  = 1'b0;
        i2c_rdata = 8'($urandom);
        log_q.push_back(tr);
        m_active = 1'b0;
      end
    end
  end

  // Reference sample: the last six served bytes, big-endian pairs.
  initial begin : monitor
    smp_t s;
    int n;
    forever begin
      @(negedge clk);
      if (sample_valid === 1'b1) begin
        n = log_q.size();
        s.cyc = cyc;
        s.x = accel_x;
        s.y = accel_y;
        s.z = accel_z;
        s.ex = 16'hxxxx;
        s.ey = 16'hxxxx;
        s.ez = 16'hxxxx;
        s.seq_ok = 1'b0;
        if (n >= 6) begin
          s.ex = {log_q[n-6].rd, log_q[n-5].rd};
          s.ey = {log_q[n-4].rd, log_q[n-3].rd};
          s.ez = {log_q[n-2].rd, log_q[n-1].rd};
          s.seq_ok = (log_q[n-1].dcyc + 1 == cyc);
          for (int k = 0; k < 6; k++)
            if (log_q[n-6+k].addr != 8'(8'h3B + k) ||
                log_q[n-6+k].rw != 1'b1)
              s.seq_ok = 1'b0;
        end
        sv_q.push_back(s);
      end
    end
  end

  task automatic do_reset();
    int g;
    en = 1'b0;
    rst = 1'b1;
    nack_addr = 8'hFF;
    g = 0;
    while (m_active && g < 50) begin
      @(posedge clk);
      g++;
    end
    repeat (2) @(posedge clk);
    log_q.delete();
    sv_q.delete();
    stab_err = 0;
    ovl_err = 0;
    #1 rst = 1'b0;
  endtask

  task automatic wait_samples(input int n, input int lim,
                              output bit ok);
    int g = 0;
    while (sv_q.size() < n && g < lim) begin
      @(negedge clk);
      g++;
    end
    ok = (sv_q.size() >= n);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en = 1'b0;
    #1;
    total++;
    if (i2c_start !== 1'b0) begin
      bad++; $display("FAIL rst_start got=%b want=0", i2c_start);
    end
    total++;
    if (sample_valid !== 1'b0) begin
      bad++; $display("FAIL rst_valid got=%b want=0", sample_valid);
    end
    total++;
    if ({init_done, error} !== 2'b00) begin
      bad++;
      $display("FAIL rst_flags got=%b%b want=00", init_done, error);
    end
    total++;
    if ({accel_x, accel_y, accel_z} !== 48'h0) begin
      bad++;
      $display("FAIL rst_accel got=%h%h%h want=0",
               accel_x, accel_y, accel_z);
    end
    total++;
    if ({i2c_rw, i2c_reg_addr, i2c_wdata} !== 17'h10000) begin
      bad++;
      $display("FAIL rst_cmd got=%b/%h/%h want=1/00/00",
               i2c_rw, i2c_reg_addr, i2c_wdata);
    end
    total++;
    if (i2c_slave_addr !== 7'h68) begin
      bad++;
      $display("FAIL slave_addr got=%h want=68", i2c_slave_addr);
    end
    do_reset();
  endtask

  task automatic test_happy();
    bit ok;
    do_reset();
    who_val = 8'h68;
    rand_burst = 1'b0;
    max_lat = 1;
    burst_b = '{8'h12, 8'h34, 8'hFF, 8'hFE, 8'h80, 8'h00};
    en = 1'b1;
    wait_samples(1, 200, ok);
    repeat (3) @(negedge clk);
    total++;
    if (!ok) begin
      bad++; $display("FAIL happy_timeout got=0 want=1 samples");
      return;
    end
    total++;
    if (log_q.size() != 8) begin
      bad++; $display("FAIL happy_ntxn got=%0d want=8", log_q.size());
    end
    total++;
    if ({log_q[0].rw, log_q[0].addr, log_q[0].wd} !== 17'h06B00) begin
      bad++;
      $display("FAIL happy_wake got=%b/%h/%h want=0/6b/00",
               log_q[0].rw, log_q[0].addr, log_q[0].wd);
    end
    total++;
    if ({log_q[1].rw, log_q[1].addr} !== 9'h175) begin
      bad++;
      $display("FAIL happy_check got=%b/%h want=1/75",
               log_q[1].rw, log_q[1].addr);
    end
    total++;
    if (init_done !== 1'b1) begin
      bad++; $display("FAIL happy_init got=%b want=1", init_done);
    end
    total++;
    if ({sv_q[0].x, sv_q[0].y, sv_q[0].z} !== 48'h1234_FFFE_8000) begin
      bad++;
      $display("FAIL happy_accel got=%h/%h/%h want=1234/fffe/8000",
               sv_q[0].x, sv_q[0].y, sv_q[0].z);
    end
    total++;
    if (!sv_q[0].seq_ok) begin
      bad++; $display("FAIL happy_latency got=0 want=1");
    end
    total++;
    if (sv_q.size() != 1) begin
      bad++; $display("FAIL happy_pulses got=%0d want=1", sv_q.size());
    end
    total++;
    if (stab_err != 0 || ovl_err != 0) begin
      bad++;
      $display("FAIL happy_proto got=%0d/%0d want=0/0",
               stab_err, ovl_err);
    end
  endtask

  task automatic test_whoami_fail();
    int g;
    int nchk;
    do_reset();
    who_val = 8'h00;
    en = 1'b1;
    g = 0;
    while (error !== 1'b1 && g < 100) begin
      @(negedge clk);
      g++;
    end
    repeat (40) @(negedge clk);
    nchk = 0;
    foreach (log_q[i]) if (log_q[i].addr == 8'h75) nchk++;
    total++;
    if (nchk != 3) begin
      bad++; $display("FAIL who_checks got=%0d want=3", nchk);
    end
    total++;
    if (log_q.size() != 4) begin
      bad++; $display("FAIL who_ntxn got=%0d want=4", log_q.size());
    end
    total++;
    if ({error, init_done} !== 2'b10) begin
      bad++;
      $display("FAIL who_flags got=%b%b want=10", error, init_done);
    end
    total++;
    if (i2c_start !== 1'b0) begin
      bad++; $display("FAIL who_start got=%b want=0", i2c_start);
    end
    who_val = 8'h68;
  endtask

  task automatic test_burst_nack();
    bit ok;
    int g;
    do_reset();
    rand_burst = 1'b1;
    max_lat = 1;
    en = 1'b1;
    wait_samples(1, 200, ok);
    nack_addr = 8'h3E;
    total++;
    if (!ok) begin
      bad++; $display("FAIL nack_first got=0 want=1 samples");
      return;
    end
    total++;
    if ({sv_q[0].x, sv_q[0].y, sv_q[0].z} !==
        {sv_q[0].ex, sv_q[0].ey, sv_q[0].ez} || !sv_q[0].seq_ok) begin
      bad++;
      $display("FAIL nack_sample got=%h%h%h want=%h%h%h",
               sv_q[0].x, sv_q[0].y, sv_q[0].z,
               sv_q[0].ex, sv_q[0].ey, sv_q[0].ez);
    end
    g = 0;
    while (error !== 1'b1 && g < 100) begin
      @(negedge clk);
      g++;
    end
    repeat (30) @(negedge clk);
    total++;
    if (error !== 1'b1) begin
      bad++; $display("FAIL nack_error got=%b want=1", error);
    end
    total++;
    if ({accel_x, accel_y, accel_z} !==
        {sv_q[0].ex, sv_q[0].ey, sv_q[0].ez}) begin
      bad++;
      $display("FAIL nack_hold got=%h%h%h want=%h%h%h",
               accel_x, accel_y, accel_z,
               sv_q[0].ex, sv_q[0].ey, sv_q[0].ez);
    end
    total++;
    if (sv_q.size() != 1) begin
      bad++; $display("FAIL nack_pulses got=%0d want=1", sv_q.size());
    end
    total++;
    if (log_q[$].addr !== 8'h3E || log_q[$].nack !== 1'b1) begin
      bad++;
      $display("FAIL nack_last got=%h want=3e", log_q[$].addr);
    end
  endtask

  task automatic test_rate();
    int g;
    int starts[$];
    do_reset();
    rand_burst = 1'b1;
    max_lat = 1;
    en = 1'b1;
    g = 0;
    while (init_done !== 1'b1 && g < 50) begin
      @(negedge clk);
      g++;
    end
    repeat (200) @(negedge clk);
    foreach (log_q[i]) if (log_q[i].addr == 8'h3B)
      starts.push_back(log_q[i].scyc);
    total++;
    if (starts.size() < 9) begin
      bad++; $display("FAIL rate_count got=%0d want>=9", starts.size());
    end
    for (int i = 1; i < starts.size(); i++) begin
      total++;
      if (starts[i] - starts[i-1] != 20) begin
        bad++;
        $display("FAIL rate_gap got=%0d want=20",
                 starts[i] - starts[i-1]);
      end
    end
    foreach (sv_q[i]) begin
      total++;
      if ({sv_q[i].x, sv_q[i].y, sv_q[i].z} !==
          {sv_q[i].ex, sv_q[i].ey, sv_q[i].ez} || !sv_q[i].seq_ok) begin
        bad++;
        $display("FAIL rate_sample got=%h%h%h want=%h%h%h",
                 sv_q[i].x, sv_q[i].y, sv_q[i].z,
                 sv_q[i].ex, sv_q[i].ey, sv_q[i].ez);
      end
    end
    total++;
    if (stab_err != 0 || ovl_err != 0) begin
      bad++;
      $display("FAIL rate_proto got=%0d/%0d want=0/0",
               stab_err, ovl_err);
    end
  endtask

  task automatic test_en_drop();
    int g;
    int hits;
    int n;
    do_reset();
    rand_burst = 1'b1;
    max_lat = 1;
    en = 1'b1;
    g = 0;
    hits = 0;
    while (hits < 2 && g < 300) begin
      @(negedge clk);
      if (i2c_start === 1'b1 && i2c_reg_addr == 8'h3D) hits++;
      g++;
    end
    total++;
    if (hits != 2) begin
      bad++; $display("FAIL drop_reach got=%0d want=2", hits);
      return;
    end
    @(posedge clk);
    #1 en = 1'b0;
    repeat (15) @(negedge clk);
    total++;
    if (init_done !== 1'b0) begin
      bad++; $display("FAIL drop_init got=%b want=0", init_done);
    end
    total++;
    if (log_q[$].addr !== 8'h3D) begin
      bad++; $display("FAIL drop_last got=%h want=3d", log_q[$].addr);
    end
    total++;
    if (sv_q.size() != 1) begin
      bad++; $display("FAIL drop_pulses got=%0d want=1", sv_q.size());
    end
    total++;
    if ({accel_x, accel_y, accel_z} !==
        {sv_q[0].ex, sv_q[0].ey, sv_q[0].ez}) begin
      bad++;
      $display("FAIL drop_hold got=%h%h%h want=%h%h%h",
               accel_x, accel_y, accel_z,
               sv_q[0].ex, sv_q[0].ey, sv_q[0].ez);
    end
    n = log_q.size();
    en = 1'b1;
    g = 0;
    while (log_q.size() == n && g < 30) begin
      @(negedge clk);
      g++;
    end
    total++;
    if ({log_q[n].rw, log_q[n].addr, log_q[n].wd} !== 17'h06B00) begin
      bad++;
      $display("FAIL drop_rewake got=%b/%h/%h want=0/6b/00",
               log_q[n].rw, log_q[n].addr, log_q[n].wd);
    end
  endtask

  task automatic test_rst_mid_check();
    int g;
    do_reset();
    who_val = 8'h68;
    max_lat = 2;
    en = 1'b1;
    g = 0;
    while (!(i2c_start === 1'b1 && i2c_reg_addr == 8'h75) && g < 50)
    begin
      @(negedge clk);
      g++;
    end
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    total++;
    if ({i2c_start, sample_valid, init_done, error} !== 4'b0000) begin
      bad++;
      $display("FAIL arst_flags got=%b%b%b%b want=0000",
               i2c_start, sample_valid, init_done, error);
    end
    total++;
    if ({i2c_rw, i2c_reg_addr, i2c_wdata} !== 17'h10000) begin
      bad++;
      $display("FAIL arst_cmd got=%b/%h/%h want=1/00/00",
               i2c_rw, i2c_reg_addr, i2c_wdata);
    end
    total++;
    if ({accel_x, accel_y, accel_z} !== 48'h0) begin
      bad++; $display("FAIL arst_accel got=%h want=0", accel_x);
    end
    g = 0;
    while (m_active && g < 50) begin
      @(posedge clk);
      g++;
    end
    repeat (2) @(posedge clk);
    log_q.delete();
    #1 rst = 1'b0;
    g = 0;
    while (log_q.size() == 0 && g < 50) begin
      @(negedge clk);
      g++;
    end
    total++;
    if ({log_q[0].rw, log_q[0].addr, log_q[0].wd} !== 17'h06B00) begin
      bad++;
      $display("FAIL arst_restart got=%b/%h/%h want=0/6b/00",
               log_q[0].rw, log_q[0].addr, log_q[0].wd);
    end
    max_lat = 1;
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b0;
    test_reset();
    test_happy();
    test_whoami_fail();
    test_burst_nack();
    test_rate();
    test_en_drop();
    test_rst_mid_check();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
